// File: rtl/irrig_pkg.sv
// Shared constants for the multi-zone irrigation controller: phase encoding and irrigation mode.
package irrig_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_FILL     = 3'd2;
    localparam logic [2:0] ST_IRRIGATE = 3'd3;
    localparam logic [2:0] ST_CLEAN    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic MODE_SPRINKLER = 1'b0;
    localparam logic MODE_DRIP      = 1'b1;

    // Pesticide in the tank must never be sprayed, so it forces drip.
    function automatic logic pick_mode(input logic air_dry, input logic temp_high,
                                       input logic pesticide);
        return (air_dry && !temp_high && !pesticide) ? MODE_SPRINKLER : MODE_DRIP;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for one timed phase: load wins over tick, expiry is the tick that sees 1.
module phase_timer #(
    parameter int TIME_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              tick,
    output logic [TIME_W-1:0] remaining,
    output logic              expire
);

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (tick && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expire = tick && (remaining == TIME_W'(1));

endmodule

// File: rtl/multi_zone_irrigation_ctrl.sv
// Round-robin irrigation sequencer sharing one pump across NUM_ZONES zones.
// Optional IRRIG_SKIP_EN adds skip_i to cut FILL/IRRIGATE short into CLEAN.
module multi_zone_irrigation_ctrl
    import irrig_pkg::*;
#(
    parameter int NUM_ZONES      = 4,
    parameter int ZONE_W         = 2,
    parameter int TIME_W         = 7,
    parameter int FILL_TIME      = 10,
    parameter int SPRINKLER_TIME = 20,
    parameter int DRIP_TIME      = 40,
    parameter int CLEAN_TIME     = 5
) (
    input  logic                 clk_50mhz,
    input  logic                 init_pulse,
    input  logic                 tick_1hz,
    input  logic                 start_i,
    input  logic [NUM_ZONES-1:0] soil_dry_i,
    input  logic [NUM_ZONES-1:0] air_dry_i,
    input  logic [NUM_ZONES-1:0] temp_high_i,
    input  logic                 pesticide_i,
`ifdef IRRIG_SKIP_EN
    input  logic                 skip_i,
`endif
    output logic                 busy,
    output logic [ZONE_W-1:0]    zone_idx,
    output logic [2:0]           phase,
    output logic                 valve_fill,
    output logic [NUM_ZONES-1:0] valve_sprinkler,
    output logic [NUM_ZONES-1:0] valve_drip,
    output logic [TIME_W-1:0]    remaining,
    output logic                 alert_pesticide,
    output logic                 round_done
);

    logic [2:0]           state, state_nxt;
    logic [ZONE_W-1:0]    zone, zone_nxt;
    logic                 mode;
    logic                 alert;
    logic                 advance;
    logic                 t_load;
    logic [TIME_W-1:0]    t_val;
    logic                 t_expire;
    logic [NUM_ZONES-1:0] zone_onehot;

    phase_timer #(.TIME_W(TIME_W)) u_timer (
        .clk       (clk_50mhz),
        .rst       (init_pulse),
        .load      (t_load),
        .load_val  (t_val),
        .tick      (tick_1hz),
        .remaining (remaining),
        .expire    (t_expire)
    );

    always_comb begin
        state_nxt = state;
        zone_nxt  = zone;
        advance   = 1'b0;
        t_load    = 1'b0;
        t_val     = '0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_SELECT;
                    zone_nxt  = '0;
                end
            end
            ST_SELECT: begin
                if (soil_dry_i[zone]) begin
                    state_nxt = ST_FILL;
                    t_load    = 1'b1;
                    t_val     = TIME_W'(FILL_TIME);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_FILL: begin
`ifdef IRRIG_SKIP_EN
                if (skip_i) begin
                    state_nxt = ST_CLEAN;
                    t_load    = 1'b1;
                    t_val     = TIME_W'(CLEAN_TIME);
                end else
`endif
                if (t_expire) begin
                    state_nxt = ST_IRRIGATE;
                    t_load    = 1'b1;
                    t_val     = (mode == MODE_SPRINKLER) ? TIME_W'(SPRINKLER_TIME)
                                                         : TIME_W'(DRIP_TIME);
                end
            end
            ST_IRRIGATE: begin
`ifdef IRRIG_SKIP_EN
                if (skip_i) begin
                    state_nxt = ST_CLEAN;
                    t_load    = 1'b1;
                    t_val     = TIME_W'(CLEAN_TIME);
                end else
`endif
                if (t_expire) begin
                    state_nxt = ST_CLEAN;
                    t_load    = 1'b1;
                    t_val     = TIME_W'(CLEAN_TIME);
                end
            end
            ST_CLEAN: begin
                if (t_expire) advance = 1'b1;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                zone_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                zone_nxt  = '0;
            end
        endcase

        if (advance) begin
            if (zone == ZONE_W'(NUM_ZONES - 1)) begin
                state_nxt = ST_DONE;
            end else begin
                state_nxt = ST_SELECT;
                zone_nxt  = zone + ZONE_W'(1);
            end
        end
    end

    // Sensors and pesticide are latched only on the SELECT edge; later changes are ignored.
    always_ff @(posedge clk_50mhz) begin
        if (init_pulse) begin
            state <= ST_IDLE;
            zone  <= '0;
            mode  <= MODE_SPRINKLER;
            alert <= 1'b0;
        end else begin
            state <= state_nxt;
            zone  <= zone_nxt;
            if (state == ST_SELECT && soil_dry_i[zone]) begin
                mode  <= pick_mode(air_dry_i[zone], temp_high_i[zone], pesticide_i);
                alert <= air_dry_i[zone] && !temp_high_i[zone] && pesticide_i;
            end else if (state == ST_CLEAN && t_expire) begin
                alert <= 1'b0;
            end
        end
    end

    assign zone_onehot     = NUM_ZONES'(1) << zone;
    assign busy            = (state == ST_SELECT) || (state == ST_FILL) ||
                             (state == ST_IRRIGATE) || (state == ST_CLEAN);
    assign zone_idx        = zone;
    assign phase           = state;
    assign valve_fill      = (state == ST_FILL);
    assign valve_sprinkler = (state == ST_IRRIGATE && mode == MODE_SPRINKLER) ? zone_onehot : '0;
    assign valve_drip      = (state == ST_IRRIGATE && mode == MODE_DRIP) ? zone_onehot : '0;
    assign alert_pesticide = alert;
    assign round_done      = (state == ST_DONE);

endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Bench for multi_zone_irrigation_ctrl: procedural round model compared every cycle plus directed literals.
module tb_multi_zone_irrigation_ctrl;

    localparam int NZ = 4;
    localparam int ZW = 2;
    localparam int TW = 7;
    localparam int FT = 10;
    localparam int ST = 20;
    localparam int DT = 40;
    localparam int CT = 5;

    logic          clk = 1'b0;
    logic          init_pulse = 1'b0;
    logic          tick_1hz = 1'b0;
    logic          start_i = 1'b0;
    logic          pesticide_i = 1'b0;
    logic [NZ-1:0] soil_dry_i = '0;
    logic [NZ-1:0] air_dry_i = '0;
    logic [NZ-1:0] temp_high_i = '0;
`ifdef IRRIG_SKIP_EN
    logic          skip_i = 1'b0;
`endif

    logic          busy, valve_fill, alert_pesticide, round_done;
    logic [ZW-1:0] zone_idx;
    logic [2:0]    phase;
    logic [NZ-1:0] valve_sprinkler, valve_drip;
    logic [TW-1:0] remaining;

    logic          f1_busy, f1_valve_fill, f1_alert, f1_done;
    logic [ZW-1:0] f1_zone;
    logic [2:0]    f1_phase;
    logic [NZ-1:0] f1_spr, f1_drip;
    logic [TW-1:0] f1_rem;

    multi_zone_irrigation_ctrl #(
        .NUM_ZONES(NZ), .ZONE_W(ZW), .TIME_W(TW), .FILL_TIME(FT),
        .SPRINKLER_TIME(ST), .DRIP_TIME(DT), .CLEAN_TIME(CT)
    ) dut (
        .clk_50mhz(clk), .init_pulse(init_pulse), .tick_1hz(tick_1hz), .start_i(start_i),
        .soil_dry_i(soil_dry_i), .air_dry_i(air_dry_i), .temp_high_i(temp_high_i),
        .pesticide_i(pesticide_i),
`ifdef IRRIG_SKIP_EN
        .skip_i(skip_i),
`endif
        .busy(busy), .zone_idx(zone_idx), .phase(phase), .valve_fill(valve_fill),
        .valve_sprinkler(valve_sprinkler), .valve_drip(valve_drip), .remaining(remaining),
        .alert_pesticide(alert_pesticide), .round_done(round_done)
    );

    // Second instance with the shortest legal fill.
    multi_zone_irrigation_ctrl #(
        .NUM_ZONES(NZ), .ZONE_W(ZW), .TIME_W(TW), .FILL_TIME(1),
        .SPRINKLER_TIME(ST), .DRIP_TIME(DT), .CLEAN_TIME(CT)
    ) dut1 (
        .clk_50mhz(clk), .init_pulse(init_pulse), .tick_1hz(tick_1hz), .start_i(start_i),
        .soil_dry_i(soil_dry_i), .air_dry_i(air_dry_i), .temp_high_i(temp_high_i),
        .pesticide_i(pesticide_i),
`ifdef IRRIG_SKIP_EN
        .skip_i(1'b0),
`endif
        .busy(f1_busy), .zone_idx(f1_zone), .phase(f1_phase), .valve_fill(f1_valve_fill),
        .valve_sprinkler(f1_spr), .valve_drip(f1_drip), .remaining(f1_rem),
        .alert_pesticide(f1_alert), .round_done(f1_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            e_phase, e_zone, e_rem;
    bit            e_busy, e_done, e_fill, e_alert;
    logic [NZ-1:0] e_spr, e_drip;
    bit            m_drip, m_alert, m_valid;

    task automatic set_exp(input int ph, input int z, input int rem);
        e_phase = ph;
        e_zone  = z;
        e_rem   = rem;
        e_busy  = (ph >= 1 && ph <= 4);
        e_done  = (ph == 5);
        e_fill  = (ph == 2);
        e_alert = m_alert;
        e_spr   = '0;
        e_drip  = '0;
        if (ph == 3) begin
            if (m_drip) e_drip[z] = 1'b1;
            else        e_spr[z]  = 1'b1;
        end
    endtask

    function automatic bit skip_now();
`ifdef IRRIG_SKIP_EN
        return skip_i;
`else
        return 1'b0;
`endif
    endfunction

    // One timed phase as a sequential walk: n ticks, with abort on reset or skip.
    task automatic run_phase(input int ph, input int z, input int n, input bit skippable,
                             output bit ab, output bit sk);
        int rem;
        bit fin;
        rem = n; fin = 0; ab = 0; sk = 0;
        while (!fin) begin
            set_exp(ph, z, rem);
            @(posedge clk);
            if (init_pulse) begin
                ab = 1; fin = 1;
            end else if (skippable && skip_now()) begin
                sk = 1; fin = 1;
            end else if (tick_1hz) begin
                if (rem == 1) fin = 1;
                else rem--;
            end
        end
    endtask

    task automatic run_round();
        bit ab, sk, sk2, spr;
        ab = 0;
        for (int z = 0; z < NZ && !ab; z++) begin
            m_alert = 0;
            set_exp(1, z, 0);
            @(posedge clk);
            if (init_pulse) begin
                ab = 1;
            end else if (soil_dry_i[z]) begin
                spr     = air_dry_i[z] && !temp_high_i[z];
                m_drip  = !spr || pesticide_i;
                m_alert = spr && pesticide_i;
                run_phase(2, z, FT, 1, ab, sk);
                if (!ab && !sk) run_phase(3, z, m_drip ? DT : ST, 1, ab, sk2);
                if (!ab) run_phase(4, z, CT, 0, ab, sk2);
                m_alert = 0;
            end
        end
        if (!ab) begin
            set_exp(5, 0, 0);
            @(posedge clk);
        end
    endtask

    initial begin
        m_valid = 0; m_drip = 0; m_alert = 0;
        set_exp(0, 0, 0);
        forever begin
            @(posedge clk);
            if (init_pulse) begin
                m_alert = 0;
                set_exp(0, 0, 0);
                m_valid = 1;
            end else if (start_i) begin
                run_round();
                m_alert = 0;
                set_exp(0, 0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("phase", phase, e_phase);
            check("busy", busy, e_busy);
            check("remaining", remaining, e_rem);
            check("valve_fill", valve_fill, e_fill);
            check("valve_sprinkler", valve_sprinkler, e_spr);
            check("valve_drip", valve_drip, e_drip);
            check("alert_pesticide", alert_pesticide, e_alert);
            check("round_done", round_done, e_done);
            if (e_busy) check("zone_idx", zone_idx, e_zone);
        end
    end

    // ---------------- tick source and observation counters ----------------
    bit tick_auto = 0;
    int tdiv = 0;
    initial forever begin
        @(posedge clk); #2;
        if (tick_auto) begin
            tick_1hz = (tdiv == 0);
            tdiv     = (tdiv == 2) ? 0 : tdiv + 1;
        end
    end

    int            c_fill, c_spr, c_spr2, c_drip, c_clean, c_fill1;
    bit            alert_seen;
    logic [NZ-1:0] last_drip = '0;
    logic [NZ-1:0] drip_q[$];

    always @(posedge clk) begin
        if (tick_1hz) begin
            if (valve_fill) c_fill++;
            if (valve_sprinkler != '0) c_spr++;
            if (valve_sprinkler == 4'b0100) c_spr2++;
            if (valve_drip != '0) c_drip++;
            if (phase == 3'd4) c_clean++;
            if (f1_valve_fill) c_fill1++;
        end
        if (alert_pesticide) alert_seen = 1;
        if (valve_drip != '0 && valve_drip != last_drip) drip_q.push_back(valve_drip);
        last_drip = valve_drip;
    end

    task automatic clr_counts();
        c_fill = 0; c_spr = 0; c_spr2 = 0; c_drip = 0; c_clean = 0; c_fill1 = 0;
        alert_seen = 0;
        drip_q.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_start();
        start_i = 1; cyc(1); start_i = 0;
    endtask

    task automatic do_reset();
        init_pulse = 1; cyc(2); init_pulse = 0;
    endtask

    task automatic wait_phase(input int ph, input int z, input int budget, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (phase == 3'(ph) && (z < 0 || zone_idx == ZW'(z))) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: timeout waiting for phase %0d zone %0d, phase is %0d", tag, ph, z, phase);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_remaining"}, remaining, 0);
        check({tag, "_valves"}, {valve_fill, valve_sprinkler, valve_drip}, 0);
        check({tag, "_round_done"}, round_done, 0);
        check({tag, "_alert"}, alert_pesticide, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int sel_cnt, done_at;
        bit any_valve;
        cyc(1);
        do_reset();
        @(negedge clk);
        chk_idle("reset");
        check("reset_zone_idx", zone_idx, 0);

        // No demand anywhere: four SELECT cycles, DONE on the fifth.
        sel_cnt = 0; done_at = 0; any_valve = 0;
        cyc(1);
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (phase == 3'd1) sel_cnt++;
            if (round_done && done_at == 0) done_at = i;
            if (valve_fill || valve_sprinkler != '0 || valve_drip != '0) any_valve = 1;
        end
        check("nodemand_selects", sel_cnt, 4);
        check("nodemand_done_cycle", done_at, 5);
        check("nodemand_no_valve", any_valve, 0);
        cyc(2);

        // Zone 2 sprinkler, with a tick on the load cycle that must not count.
        do_reset();
        clr_counts();
        soil_dry_i = 4'b0100; air_dry_i = 4'b0100; temp_high_i = '0; pesticide_i = 0;
        pulse_start();
        wait_phase(1, 2, 20, "sel_z2");
        tick_1hz = 1;
        @(posedge clk); #2;
        tick_1hz = 0;
        @(negedge clk);
        check("fill_entry_phase", phase, 2);
        check("fill_entry_remaining", remaining, FT);
        tick_1hz = 1;
        @(posedge clk); #2;
        tick_1hz = 0;
        @(negedge clk);
        check("fill_after_tick", remaining, FT - 1);
        tdiv = 0;
        tick_auto = 1;
        wait_phase(5, -1, 1000, "spr_done");
        check("spr_fill_ticks", c_fill, 10);
        check("spr_irrigate_ticks", c_spr2, 20);
        check("spr_clean_ticks", c_clean, 5);
        check("spr_alert_seen", alert_seen, 0);
        check("fill1_ticks", c_fill1, 1);
        cyc(2);

        // Pesticide forces drip on zone 2; pesticide dropping later has no effect.
        do_reset();
        clr_counts();
        pesticide_i = 1;
        pulse_start();
        wait_phase(3, 2, 500, "pest_irr");
        pesticide_i = 0;
        wait_phase(5, -1, 1500, "pest_done");
        check("pest_drip_ticks", c_drip, 40);
        check("pest_drip_zones", drip_q.size(), 1);
        if (drip_q.size() == 1) check("pest_drip_valve", drip_q[0], 4'b0100);
        check("pest_spr_ticks", c_spr, 0);
        check("pest_alert_seen", alert_seen, 1);
        check("pest_alert_cleared", alert_pesticide, 0);
        cyc(2);

        // All zones dry and hot: drip on zones 0..3 in order; mid-round start ignored.
        do_reset();
        clr_counts();
        soil_dry_i = 4'b1111; air_dry_i = 4'b1111; temp_high_i = 4'b1111;
        pulse_start();
        wait_phase(3, 0, 500, "all_irr0");
        pulse_start();
        wait_phase(5, -1, 3000, "all_done");
        check("all_drip_ticks", c_drip, 160);
        check("all_spr_ticks", c_spr, 0);
        check("all_drip_zones", drip_q.size(), 4);
        if (drip_q.size() == 4)
            for (int i = 0; i < 4; i++) check("all_drip_order", drip_q[i], 32'(1) << i);
        cyc(2);

        // Reset during IRRIGATE of zone 1 closes everything on that edge.
        do_reset();
        pulse_start();
        wait_phase(3, 1, 1500, "rst_irr1");
        init_pulse = 1;
        @(posedge clk); #2;
        init_pulse = 0;
        @(negedge clk);
        chk_idle("midround_reset");
        cyc(3);

`ifdef IRRIG_SKIP_EN
        // Skip in IRRIGATE goes straight to a full CLEAN.
        do_reset();
        soil_dry_i = 4'b0100; air_dry_i = 4'b0100; temp_high_i = '0; pesticide_i = 0;
        pulse_start();
        wait_phase(3, 2, 500, "skip_irr");
        skip_i = 1;
        @(posedge clk); #2;
        skip_i = 0;
        @(negedge clk);
        check("skip_phase", phase, 4);
        check("skip_remaining", remaining, CT);
        check("skip_valves", valve_sprinkler, 0);
        wait_phase(5, -1, 500, "skip_done");
        cyc(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
